// File: rtl/cla_pkg.sv
// Shared constants and types for the pipelined carry-lookahead adder.
package cla_pkg;

    localparam int GROUP = 4;

    // Per-group propagate, generate and resulting sum bits.
    typedef struct packed {
        logic [GROUP-1:0] p;
        logic [GROUP-1:0] g;
        logic [GROUP-1:0] s;
    } grp_pg_t;

endpackage

// File: rtl/cla_group4.sv
// Combinational 4-bit carry-lookahead group: all carries are formed
// directly from P/G terms and the group carry-in.
module cla_group4
    import cla_pkg::*;
(
    input  logic [GROUP-1:0] a,
    input  logic [GROUP-1:0] b,
    input  logic             c_in,
    output logic [GROUP-1:0] sum,
    output logic             c_out,
    output logic             c_msb_in
);

    grp_pg_t        pg;
    logic [GROUP:0] c;

    always_comb begin
        pg.p = a ^ b;
        pg.g = a & b;
        c[0] = c_in;
        c[1] = pg.g[0] | (pg.p[0] & c_in);
        c[2] = pg.g[1] | (pg.p[1] & pg.g[0]) | (pg.p[1] & pg.p[0] & c_in);
        c[3] = pg.g[2] | (pg.p[2] & pg.g[1]) | (pg.p[2] & pg.p[1] & pg.g[0])
             | (pg.p[2] & pg.p[1] & pg.p[0] & c_in);
        c[4] = pg.g[3] | (pg.p[3] & pg.g[2]) | (pg.p[3] & pg.p[2] & pg.g[1])
             | (pg.p[3] & pg.p[2] & pg.p[1] & pg.g[0])
             | (pg.p[3] & pg.p[2] & pg.p[1] & pg.p[0] & c_in);
        pg.s = pg.p ^ c[GROUP-1:0];
    end

    assign sum      = pg.s;
    assign c_out    = c[GROUP];
    assign c_msb_in = c[GROUP-1];

endmodule

// File: rtl/cla_pipe_adder.sv
// Pipelined adder/subtractor: one 4-bit lookahead group per stage, the group
// carry registered between stages, with a single global advance enable.
module cla_pipe_adder #(
    parameter int WIDTH = 16,
    parameter int GROUP = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NGROUPS = WIDTH / GROUP;

    logic                          adv;
    logic [WIDTH-1:0]              b_eff;
    logic                          c0;
    logic [NGROUPS-1:0]            vld_p;
    logic [WIDTH-1:0]              a_p   [NGROUPS];
    logic [WIDTH-1:0]              b_p   [NGROUPS];
    logic [WIDTH-1:0]              sum_p [NGROUPS];
    logic                          c_p   [NGROUPS];
    logic [NGROUPS-1:0][GROUP-1:0] grp_a;
    logic [NGROUPS-1:0][GROUP-1:0] grp_b;
    logic [NGROUPS-1:0][GROUP-1:0] grp_sum;
    logic [NGROUPS-1:0]            grp_cin;
    logic [NGROUPS-1:0]            grp_cout;
    logic [NGROUPS-1:0]            grp_cmsb;
    logic [WIDTH-1:0]              sum_prev;

    assign adv       = ~out_valid | out_ready;
    assign in_ready  = adv;
    assign out_valid = vld_p[NGROUPS-1];
    // Subtraction is A + ~B + 1; the external carry-in is ignored then.
    assign b_eff     = sub ? ~b : b;
    assign c0        = sub ? 1'b1 : cin;

    for (genvar k = 0; k < NGROUPS; k++) begin : g_stage
        if (k == 0) begin : g_first
            assign grp_a[k]   = a[GROUP-1:0];
            assign grp_b[k]   = b_eff[GROUP-1:0];
            assign grp_cin[k] = c0;
        end else begin : g_next
            assign grp_a[k]   = a_p[k-1][GROUP*k +: GROUP];
            assign grp_b[k]   = b_p[k-1][GROUP*k +: GROUP];
            assign grp_cin[k] = c_p[k-1];
        end

        cla_group4 u_group (
            .a        (grp_a[k]),
            .b        (grp_b[k]),
            .c_in     (grp_cin[k]),
            .sum      (grp_sum[k]),
            .c_out    (grp_cout[k]),
            .c_msb_in (grp_cmsb[k])
        );
    end

    if (NGROUPS == 1) begin : g_prev_none
        assign sum_prev = '0;
    end else begin : g_prev_reg
        assign sum_prev = sum_p[NGROUPS-2];
    end

    // Stages 0..NGROUPS-2: operands ride along, finished sum bits accumulate.
    always_ff @(posedge clk) begin
        if (adv) begin
            a_p[0]                <= a;
            b_p[0]                <= b_eff;
            c_p[0]                <= grp_cout[0];
            sum_p[0]              <= '0;
            sum_p[0][GROUP-1:0]   <= grp_sum[0];
            for (int k = 1; k < NGROUPS - 1; k++) begin
                a_p[k]                   <= a_p[k-1];
                b_p[k]                   <= b_p[k-1];
                c_p[k]                   <= grp_cout[k];
                sum_p[k]                 <= sum_p[k-1];
                sum_p[k][GROUP*k +: GROUP] <= grp_sum[k];
            end
        end
    end

    // Final stage and all valid bits: cleared by reset, frozen during stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else if (adv) begin
            vld_p[0] <= in_valid;
            for (int k = 1; k < NGROUPS; k++) begin
                vld_p[k] <= vld_p[k-1];
            end
            sum                     <= sum_prev;
            sum[WIDTH-1 -: GROUP]   <= grp_sum[NGROUPS-1];
            cout                    <= grp_cout[NGROUPS-1];
            ovf                     <= grp_cmsb[NGROUPS-1] ^ grp_cout[NGROUPS-1];
        end
    end

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Scoreboard bench for cla_pipe_adder (WIDTH=16, four pipeline stages).
module tb_cla_pipe_adder;

    localparam int WIDTH = 16;
    localparam int NG    = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             cin = 1'b0;
    logic             sub = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    cla_pipe_adder #(.WIDTH(WIDTH), .GROUP(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [WIDTH-1:0] s;
        logic             co;
        logic             ov;
        bit               lat;
        int               t0;
    } exp_t;

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             c;
        logic             s;
        logic [WIDTH-1:0] es;
        logic             eco;
        logic             eov;
    } vec_t;

    exp_t q[$];
    vec_t vt[9];
    int   total = 0;
    int   bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Present one beat, hold it until accepted, and queue its expected result.
    task automatic send(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                        input logic tc, input logic ts,
                        input logic [WIDTH-1:0] es, input logic eco, input logic eov,
                        input bit lat);
        int   n = 0;
        bit   ok = 0;
        exp_t e;
        a = ta; b = tb; cin = tc; sub = ts; in_valid = 1'b1;
        while (!ok && n < 50) begin
            @(negedge clk);
            ok = in_ready;
            if (ok) begin
                e.s = es; e.co = eco; e.ov = eov; e.lat = lat; e.t0 = cyc;
                q.push_back(e);
            end
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        if (!ok) check("accept_timeout", 32'd0, 32'd1);
    endtask

    // Monitor: compare every presented beat against the scoreboard head.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (q.size() == 0) begin
                check("unexpected_beat", 32'd1, 32'd0);
            end else begin
                check("sum",  32'(sum),  32'(q[0].s));
                check("cout", 32'(cout), 32'(q[0].co));
                check("ovf",  32'(ovf),  32'(q[0].ov));
                if (out_ready) begin
                    if (q[0].lat) check("latency", 32'(cyc - q[0].t0), 32'(NG));
                    void'(q.pop_front());
                end
            end
        end
    end

    initial begin
        int n;
        int stale;
        vt[0] = '{16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0};
        vt[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        vt[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        vt[3] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vt[4] = '{16'h00FF, 16'h0000, 1'b1, 1'b0, 16'h0100, 1'b0, 1'b0};
        vt[5] = '{16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0};
        vt[6] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        vt[7] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
        vt[8] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};

        #1 rst_n = 1'b0;
        #2;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_sum",       32'(sum),       32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Isolated directed vectors, latency checked on each.
        for (int i = 0; i < 9; i++) begin
            send(vt[i].a, vt[i].b, vt[i].c, vt[i].s, vt[i].es, vt[i].eco, vt[i].eov, 1'b1);
            repeat (6) @(posedge clk);
            #1;
        end

        // Back-to-back beats a=i, b=2i.
        for (int i = 1; i <= 8; i++) begin
            send(16'(i), 16'(2 * i), 1'b0, 1'b0, 16'(3 * i), 1'b0, 1'b0, 1'b1);
        end
        repeat (8) @(posedge clk);
        #1;

        // Stall the output for three cycles with the pipeline full.
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    send(16'h1000 + 16'(i), 16'(i), 1'b0, 1'b0,
                         16'h1000 + 16'(2 * i), 1'b0, 1'b0, 1'b0);
                end
            end
            begin
                repeat (5) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    check("stall_in_ready",  32'(in_ready),  32'd0);
                    check("stall_out_valid", 32'(out_valid), 32'd1);
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        repeat (12) @(posedge clk);
        #1;
        check("drained", 32'(q.size()), 32'd0);

        // Reset with beats in flight and the head one stalled at the output.
        out_ready = 1'b0;
        send(16'hFFFF, 16'h0002, 1'b0, 1'b0, 16'h0001, 1'b1, 1'b0, 1'b0);
        send(16'h0003, 16'h0004, 1'b0, 1'b0, 16'h0007, 1'b0, 1'b0, 1'b0);
        send(16'h0100, 16'h0100, 1'b0, 1'b0, 16'h0200, 1'b0, 1'b0, 1'b0);
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("inflight_present", 32'(out_valid), 32'd1);
        #2 rst_n = 1'b0;
        q.delete();
        #1;
        check("async_rst_out_valid", 32'(out_valid), 32'd0);
        check("async_rst_sum",       32'(sum),       32'd0);
        check("async_rst_cout",      32'(cout),      32'd0);
        check("async_rst_in_ready",  32'(in_ready),  32'd1);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        stale = 0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        check("stale_beats", 32'(stale), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cla_pipe_adder.md
CLA_PIPE_ADDER -- requirements
Module: cla_pipe_adder

Interface
REQ-001 Parameter WIDTH, default 16, operand width; SHALL be a multiple of 4 and at least 4.
REQ-002 Parameter GROUP, default 4, bits per carry-lookahead group; fixed at 4, other values are not legal.
REQ-003 Derived NGROUPS = WIDTH/GROUP SHALL equal the pipeline depth.
REQ-004 clk  input  1  single clock, all state on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 in_valid  input  1  operand beat present.
REQ-007 in_ready  output  1  block accepts a beat this cycle.
REQ-008 a  input  WIDTH  operand A.
REQ-009 b  input  WIDTH  operand B.
REQ-010 cin  input  1  carry-in, used only when sub=0.
REQ-011 sub  input  1  0: A+B+cin; 1: A-B (A + ~B + 1).
REQ-012 out_valid  output  1  result beat present.
REQ-013 out_ready  input  1  downstream accepts result.
REQ-014 sum  output  WIDTH  result bits.
REQ-015 cout  output  1  carry out of MSB (for sub=1, 1 means no borrow).
REQ-016 ovf  output  1  two's-complement signed overflow.

Function
REQ-017 Stage k (0..NGROUPS-1) SHALL compute group k (bits 4k+3..4k) with 4-bit carry-lookahead, using the carry registered by stage k-1 (stage 0 uses effective carry-in).
REQ-018 Operand bits of groups not yet computed SHALL travel with the beat in pipeline registers; finished sum bits SHALL likewise be carried forward.
REQ-019 Latency SHALL be exactly NGROUPS cycles from accepted input (in_valid & in_ready) to out_valid, absent stalls.
REQ-020 Throughput SHALL be one beat per cycle while out_ready=1.
REQ-021 Global advance enable SHALL be adv = ~out_valid | out_ready; in_ready SHALL equal adv.
REQ-022 When adv=0 every stage register, including valid bits, SHALL hold.
REQ-023 When adv=1 and in_valid=0 a bubble (valid=0) SHALL enter stage 0; bubbles SHALL propagate and never assert out_valid.
REQ-024 Beats SHALL leave in acceptance order, none dropped or duplicated.
REQ-025 sub=1 SHALL invert B and force carry-in 1 at stage 0; cin SHALL be ignored.
REQ-026 ovf SHALL equal carry into MSB XOR carry out of MSB.
REQ-027 sum, cout, ovf SHALL be stable while out_valid=1 and out_ready=0.
REQ-028 Arithmetic SHALL wrap modulo 2^WIDTH; cout carries the dropped bit.

Reset
REQ-029 rst_n=0 SHALL asynchronously clear all valid bits, sum, cout, ovf to 0, including beats in flight.
REQ-030 While rst_n=0 in_ready SHALL be 1 (adv=1 since out_valid=0); no beat is accepted until the first rising edge with rst_n=1.
REQ-031 Data registers other than outputs need not be reset.

Structure
REQ-032 Package cla_pkg SHALL hold GROUP=4 constant and a group P/G record type (p, g, 4-bit sum).
REQ-033 Sub-module cla_group4 (combinational 4-bit lookahead: a, b, c_in -> sum, c_out, c_msb_in) SHALL be instantiated NGROUPS times.

Verification (WIDTH=16, latency 4)
REQ-034 a=16'h0001, b=16'h0001, cin=0, sub=0 -> 4 cycles later sum=16'h0002, cout=0, ovf=0.
REQ-035 a=16'hFFFF, b=16'h0001, cin=0 -> sum=16'h0000, cout=1, ovf=0 (carry ripples through all 4 stages).
REQ-036 a=16'h7FFF, b=16'h0001 -> sum=16'h8000, ovf=1, cout=0; a=16'h0005, b=16'h0007, sub=1 -> sum=16'hFFFE, cout=0, ovf=0.
REQ-037 Back-to-back 8 beats (a=i, b=2i), out_ready=1 -> 8 consecutive out_valid cycles, sum=3i in order.
REQ-038 out_ready=0 for 3 cycles while pipeline full -> in_ready=0, outputs held, no loss; resume -> remaining beats in order.
REQ-039 rst_n pulled low with 3 beats in flight -> out_valid=0, sum=0 immediately; after release no stale beat appears.
